// File: rtl/button_conditioner.sv
// Four-channel push-button synchroniser/debouncer emitting one-cycle press pulses plus a colour Conflict flag.
// Latency: pulse registered DB_CYCLES+1 edges after the first edge that samples a stable press; no backpressure.
module button_conditioner #(
    parameter int DB_CYCLES = 4,
    parameter int CNT_W     = 3
) (
    input  logic Clk,
    input  logic Rst,
    input  logic StartBtn,
    input  logic RedBtn,
    input  logic GreenBtn,
    input  logic BlueBtn,
    output logic Start,
    output logic Red,
    output logic Green,
    output logic Blue,
    output logic Conflict
);

    typedef enum logic [1:0] {IDLE, ARMING, PRESSED, RELEASING} state_t;

    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Channel order: 0 Start, 1 Red, 2 Green, 3 Blue.
    logic [3:0]       raw;
    logic [3:0]       meta;
    logic [3:0]       sync;
    state_t           state     [4];
    state_t           state_nxt [4];
    logic [CNT_W-1:0] cnt       [4];
    logic [CNT_W-1:0] cnt_nxt   [4];
    logic [3:0]       pulse;
    logic [3:0]       pulse_nxt;
    logic             conflict;
    logic             conflict_nxt;

    assign raw = {BlueBtn, GreenBtn, RedBtn, StartBtn};

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            meta     <= '0;
            sync     <= '0;
            pulse    <= '0;
            conflict <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                state[i] <= IDLE;
                cnt[i]   <= '0;
            end
        end else begin
            meta     <= raw;
            sync     <= meta;
            pulse    <= pulse_nxt;
            conflict <= conflict_nxt;
            for (int i = 0; i < 4; i++) begin
                state[i] <= state_nxt[i];
                cnt[i]   <= cnt_nxt[i];
            end
        end
    end

    always_comb begin
        pulse_nxt = '0;
        for (int i = 0; i < 4; i++) begin
            state_nxt[i] = state[i];
            cnt_nxt[i]   = cnt[i];
            case (state[i])
                IDLE: begin
                    if (sync[i]) begin
                        state_nxt[i] = ARMING;
                        cnt_nxt[i]   = CNT_ONE;
                    end
                end
                ARMING: begin
                    if (!sync[i]) begin
                        state_nxt[i] = IDLE;
                        cnt_nxt[i]   = '0;
                    end else if (cnt[i] == CNT_TOP) begin
                        state_nxt[i] = PRESSED;
                        cnt_nxt[i]   = '0;
                        pulse_nxt[i] = 1'b1;
                    end else begin
                        cnt_nxt[i] = cnt[i] + CNT_ONE;
                    end
                end
                PRESSED: begin
                    if (!sync[i]) begin
                        state_nxt[i] = RELEASING;
                        cnt_nxt[i]   = CNT_ONE;
                    end
                end
                RELEASING: begin
                    // A bounce back high resumes the held press without a second pulse.
                    if (sync[i]) begin
                        state_nxt[i] = PRESSED;
                        cnt_nxt[i]   = '0;
                    end else if (cnt[i] == CNT_TOP) begin
                        state_nxt[i] = IDLE;
                        cnt_nxt[i]   = '0;
                    end else begin
                        cnt_nxt[i] = cnt[i] + CNT_ONE;
                    end
                end
                default: begin
                    state_nxt[i] = IDLE;
                    cnt_nxt[i]   = '0;
                end
            endcase
        end
        conflict_nxt = (pulse_nxt[1] & pulse_nxt[2]) |
                       (pulse_nxt[1] & pulse_nxt[3]) |
                       (pulse_nxt[2] & pulse_nxt[3]);
    end

    assign Start    = pulse[0];
    assign Red      = pulse[1];
    assign Green    = pulse[2];
    assign Blue     = pulse[3];
    assign Conflict = conflict;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner (DB_CYCLES=4): edge k is the k-th rising Clk edge after a test starts;
// outputs are sampled 1 time unit after each edge, so a pulse "during the cycle after edge 5" is seen at k==5.
module tb_button_conditioner;

    logic Clk;
    logic Rst;
    logic StartBtn, RedBtn, GreenBtn, BlueBtn;
    logic Start, Red, Green, Blue, Conflict;

    int total;
    int bad;

    button_conditioner #(.DB_CYCLES(4), .CNT_W(3)) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .StartBtn (StartBtn),
        .RedBtn   (RedBtn),
        .GreenBtn (GreenBtn),
        .BlueBtn  (BlueBtn),
        .Start    (Start),
        .Red      (Red),
        .Green    (Green),
        .Blue     (Blue),
        .Conflict (Conflict)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Buttons low, reset held for three edges, then released so the next edge is edge 0.
    task automatic do_reset();
        Rst      = 1'b0;
        StartBtn = 1'b0;
        RedBtn   = 1'b0;
        GreenBtn = 1'b0;
        BlueBtn  = 1'b0;
        repeat (3) tick();
        Rst = 1'b1;
    endtask

    task automatic test_reset();
        Rst      = 1'b0;
        StartBtn = 1'b1;
        RedBtn   = 1'b1;
        GreenBtn = 1'b1;
        BlueBtn  = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            total++;
            if ({Start, Red, Green, Blue, Conflict} !== 5'b00000) begin
                bad++;
                $display("FAIL reset_outputs edge=%0d got=%b want=00000", k, {Start, Red, Green, Blue, Conflict});
            end
        end
        do_reset();
    endtask

    task automatic test_clean_press();
        do_reset();
        RedBtn = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            total++;
            if (Red !== (k == 5)) begin
                bad++;
                $display("FAIL clean_red edge=%0d got=%b want=%b", k, Red, (k == 5));
            end
            total++;
            if ({Start, Green, Blue, Conflict} !== 4'b0000) begin
                bad++;
                $display("FAIL clean_others edge=%0d got=%b want=0000", k, {Start, Green, Blue, Conflict});
            end
        end
    endtask

    task automatic test_bounce();
        logic [4:0] pat;
        do_reset();
        pat = 5'b01101; // bit k is the raw level before edge k
        for (int k = 0; k < 20; k++) begin
            RedBtn = (k < 5) ? pat[k] : 1'b1;
            tick();
            total++;
            if (Red !== (k == 10)) begin
                bad++;
                $display("FAIL bounce_red edge=%0d got=%b want=%b", k, Red, (k == 10));
            end
        end
    endtask

    task automatic test_release_glitch();
        do_reset();
        for (int k = 0; k < 45; k++) begin
            RedBtn = (k < 10) || (k >= 12 && k < 22) || (k >= 30);
            tick();
            total++;
            if (Red !== (k == 5 || k == 35)) begin
                bad++;
                $display("FAIL glitch_red edge=%0d got=%b want=%b", k, Red, (k == 5 || k == 35));
            end
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        RedBtn  = 1'b1;
        BlueBtn = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            total++;
            if ({Red, Blue, Conflict} !== {3{k == 5}}) begin
                bad++;
                $display("FAIL simul_rbc edge=%0d got=%b want=%b", k, {Red, Blue, Conflict}, {3{k == 5}});
            end
            total++;
            if ({Start, Green} !== 2'b00) begin
                bad++;
                $display("FAIL simul_sg edge=%0d got=%b want=00", k, {Start, Green});
            end
        end
    endtask

    task automatic test_reset_mid_arming();
        do_reset();
        GreenBtn = 1'b1;
        for (int k = 0; k < 15; k++) begin
            Rst = (k == 3) ? 1'b0 : 1'b1;
            tick();
            total++;
            if (Green !== (k == 9)) begin
                bad++;
                $display("FAIL midrst_green edge=%0d got=%b want=%b", k, Green, (k == 9));
            end
            if (k == 3) begin
                total++;
                if ({Start, Red, Green, Blue, Conflict} !== 5'b00000) begin
                    bad++;
                    $display("FAIL midrst_outputs edge=%0d got=%b want=00000", k, {Start, Red, Green, Blue, Conflict});
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        // Sequence Start, Red, Blue, Green, Red; each button index is {S,R,G,B} = 0..3.
        int seq [5];
        int step;
        int pos;
        logic [3:0] btn;
        logic [3:0] want;
        seq = '{0, 1, 3, 2, 1};
        do_reset();
        for (int k = 0; k < 100; k++) begin
            step = k / 20;
            pos  = k % 20;
            btn  = '0;
            if (pos < 10) btn[seq[step]] = 1'b1;
            {BlueBtn, GreenBtn, RedBtn, StartBtn} = btn;
            tick();
            want = '0;
            if (pos == 5) want[seq[step]] = 1'b1;
            total++;
            if ({Blue, Green, Red, Start} !== want) begin
                bad++;
                $display("FAIL seq_pulses edge=%0d got=%b want=%b", k, {Blue, Green, Red, Start}, want);
            end
            total++;
            if (Conflict !== 1'b0) begin
                bad++;
                $display("FAIL seq_conflict edge=%0d got=%b want=0", k, Conflict);
            end
        end
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        Rst      = 1'b0;
        StartBtn = 1'b0;
        RedBtn   = 1'b0;
        GreenBtn = 1'b0;
        BlueBtn  = 1'b0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_release_glitch();
        test_simultaneous();
        test_reset_mid_arming();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Front-end stage directly upstream of the colour-code detector.
- Takes four raw, asynchronous, bouncing push-button levels (Start, Red, Green, Blue) and produces clean, synchronous, single-cycle press pulses that the detector consumes.
- Each channel has its own 2-flop synchroniser, debounce counter and press/release FSM.
- Also flags cycles where more than one colour press is reported at once.

Parameters:
- DB_CYCLES, default 4: consecutive identical synchronised samples required to accept a press or a release. Legal range is DB_CYCLES >= 2.
- CNT_W, default 3: width of each debounce counter. Must satisfy 2^CNT_W > DB_CYCLES-1.

Ports:
- Clk, input, 1: system clock; all logic on the rising edge.
- Rst, input, 1: synchronous, active-low reset (0 = reset).
- StartBtn, input, 1: raw asynchronous Start button level.
- RedBtn, input, 1: raw asynchronous Red button level.
- GreenBtn, input, 1: raw asynchronous Green button level.
- BlueBtn, input, 1: raw asynchronous Blue button level.
- Start, output, 1: one-cycle pulse per accepted Start press.
- Red, output, 1: one-cycle pulse per accepted Red press.
- Green, output, 1: one-cycle pulse per accepted Green press.
- Blue, output, 1: one-cycle pulse per accepted Blue press.
- Conflict, output, 1: one-cycle pulse when two or more of Red/Green/Blue pulse in the same cycle.

Behaviour:

Clock and reset:
- Single clock domain.
- Reset is synchronous and active-low: Rst sampled 0 at a rising Clk edge resets the block.

Reset values:
- All outputs are 0.
- All synchroniser flops are 0.
- All channel FSMs are in IDLE.
- All counters are 0.

Synchroniser:
- Per channel, two flops in series. The output s is the raw level delayed two edges.

Channel FSM (identical for all four channels), states IDLE, ARMING, PRESSED, RELEASING:
- IDLE:
  - s=1 -> ARMING, cnt=1.
  - Otherwise stay in IDLE.
- ARMING:
  - s=0 -> IDLE, cnt=0.
  - s=1 and cnt==DB_CYCLES-1 -> PRESSED. The pulse output is registered 1 at this same edge.
  - Otherwise cnt++.
- PRESSED:
  - s=0 -> RELEASING, cnt=1.
  - Otherwise stay in PRESSED.
- RELEASING:
  - s=1 -> PRESSED, cnt=0. No new pulse.
  - s=0 and cnt==DB_CYCLES-1 -> IDLE.
  - Otherwise cnt++.

Pulse outputs:
- Each pulse output is a register.
- It is high for exactly one cycle, following the ARMING->PRESSED edge.
- At all other times it is 0.
- Release never generates a pulse.

Press latency:
- Raw input rises and stays stable before edge 0. The pulse is high during the cycle following edge DB_CYCLES+1.
- With DB_CYCLES=4 this is edge 5.
- A press must be stable for DB_CYCLES synchronised samples to be accepted.

Bounce rejection:
- Any glitch or high run shorter than DB_CYCLES samples produces no pulse.
- A low glitch shorter than DB_CYCLES while PRESSED produces no second pulse.

Hold:
- A button held indefinitely produces exactly one pulse.
- A new pulse requires a full debounced release first.

Simultaneous events:
- Channels are independent.
- Simultaneous colour pulses are all passed through, and are not arbitrated.
- Conflict=1 in the same cycle as the pulses when popcount(Red,Green,Blue) >= 2.
- Start does not participate in Conflict.

Reset mid-operation:
- Any channel returns to IDLE and counters clear.
- A pulse pending for the next edge is suppressed.
- Outputs are 0 in the cycle following the reset edge.

Button held across reset:
- After Rst returns to 1, the held button is treated as a new press.
- Pulse arrives DB_CYCLES+1 edges after the first non-reset edge.

No combinational path from any input to any output.

Test Plan:
1. Clean press, DB_CYCLES=4: RedBtn 0->1 before edge 0, held 20 cycles -> Red=1 during cycle after edge 5 only; Green, Blue, Start, Conflict stay 0.
2. Bounce: RedBtn toggles 1,0,1,1,0 at edges 0-4, then held 1 -> no pulse during bounce; single Red pulse 5 edges after the final stable rise.
3. Release glitch: Red held and pulsed, then RedBtn low for 2 cycles and high again -> no second pulse. Full release for 8 cycles, then re-press -> second pulse.
4. Simultaneous press: RedBtn and BlueBtn rise on the same cycle -> Red=1, Blue=1, Conflict=1 in the same cycle; Green=0.
5. Reset mid-ARMING: GreenBtn rises, Rst=0 at edge 3, Rst=1 from edge 4, GreenBtn held -> no pulse before edge 4; Green pulse after edge 4+DB_CYCLES+1=9; all outputs 0 during reset.
6. Full code sequence: Start, Red, Blue, Green, Red, each pressed 10 cycles with 10-cycle releases -> exactly one pulse each, in order; Conflict never asserted.
